// File: rtl/sparten_mac_engine_if.sv
// sparten_mac_engine_if: chunk-in / result-out bus of the sparse MAC engine.
//
// Both directions use the same valid/ready rule: a transfer happens on the
// rising clk edge where valid and ready are both high; the source keeps valid
// and its payload steady until that edge, and ready may depend on state only.
//
// master: drives chunks and consumes results (source / consumer side).
// slave : the engine.
interface sparten_mac_engine_if #(
    parameter int CHUNK_SIZE = 128,
    parameter int Q          = 8,
    parameter int ACC_W      = 2*Q + $clog2(CHUNK_SIZE),
    parameter int MC_W       = $clog2(CHUNK_SIZE) + 1
);
    // Chunk side
    logic                    in_valid;
    logic                    in_ready;
    logic                    acc_clear;
    logic [CHUNK_SIZE-1:0]   input_sparsemap;
    logic [CHUNK_SIZE-1:0]   filter_sparsemap;
    logic [CHUNK_SIZE*Q-1:0] input_data;
    logic [CHUNK_SIZE*Q-1:0] filter_data;

    // Result side
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        result;
    logic [MC_W-1:0]         match_count;

    modport master (
        output in_valid, acc_clear, input_sparsemap, filter_sparsemap,
               input_data, filter_data, out_ready,
        input  in_ready, out_valid, result, match_count
    );

    modport slave (
        input  in_valid, acc_clear, input_sparsemap, filter_sparsemap,
               input_data, filter_data, out_ready,
        output in_ready, out_valid, result, match_count
    );
endinterface

// File: rtl/sparten_mac_engine.sv
// sparten_mac_engine: multi-lane sparse dot-product engine.
//
// One chunk = two bitmaps plus two compacted nonzero arrays. The engine
// inner-joins the bitmaps and retires up to LANES matched positions per RUN
// cycle, lowest positions first. For a match at position p the operand index
// is the popcount of the corresponding bitmap below p. Products are signed
// Q x Q, sign-extended and summed into a wrapping ACC_W accumulator that is
// either cleared or carried across chunks (acc_clear, sampled at accept).
//
// Optional build macro SPARTEN_RELU_EN: when defined, the presented result is
// clamped to 0 for a negative accumulator; the accumulator itself stays raw so
// chained chunks remain exact. Latency and handshake are the same either way.
//
// FSM: IDLE (accept chunk) -> RUN (retire matches) -> DONE (hold result).
// o_state exposes the FSM state for observation.
module sparten_mac_engine #(
    parameter int CHUNK_SIZE = 128,
    parameter int Q          = 8,
    parameter int LANES      = 2,
    parameter int ACC_W      = 2*Q + $clog2(CHUNK_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sparten_mac_engine_if.slave  bus,
    output logic [1:0]           o_state
);

    localparam int PW   = $clog2(CHUNK_SIZE);   // bit position / operand index width
    localparam int MC_W = PW + 1;               // match counter width (0..CHUNK_SIZE)
    localparam int LW   = $clog2(LANES + 1);    // lanes-used counter width (0..LANES)
    localparam logic [CHUNK_SIZE-1:0] ONE_C = CHUNK_SIZE'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Registered chunk
    logic [CHUNK_SIZE-1:0]   r_in_map;
    logic [CHUNK_SIZE-1:0]   r_flt_map;
    logic [CHUNK_SIZE*Q-1:0] r_in_data;
    logic [CHUNK_SIZE*Q-1:0] r_flt_data;
    logic [CHUNK_SIZE-1:0]   r_pending;     // join positions not yet retired

    // Accumulation state
    logic [ACC_W-1:0]        r_acc;
    logic [MC_W-1:0]         r_match_count;

    // Per-position operand indices (exclusive prefix popcount of each map)
    logic [PW-1:0]           w_in_pre  [CHUNK_SIZE];
    logic [PW-1:0]           w_flt_pre [CHUNK_SIZE];

    // One RUN step
    logic [CHUNK_SIZE-1:0]   w_pending_next;
    logic [ACC_W-1:0]        w_acc_next;
    logic [LW-1:0]           w_used;

    logic                    w_accept;

    assign w_accept = bus.in_valid && bus.in_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: RUN always lasts at least one cycle, even for an empty join
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_RUN;
            S_RUN:  if (w_pending_next == '0) w_state_next = S_DONE;
            S_DONE: if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: ready only while idle, valid only while holding a result
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE:  bus.in_ready  = 1'b1;
            S_DONE:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Exclusive prefix popcounts: index of the nonzero at position p in each array
    always_comb begin
        logic [PW-1:0] w_cnt_i;
        logic [PW-1:0] w_cnt_f;
        w_cnt_i = '0;
        w_cnt_f = '0;
        for (int i = 0; i < CHUNK_SIZE; i++) begin
            w_in_pre[i]  = w_cnt_i;
            w_flt_pre[i] = w_cnt_f;
            w_cnt_i      = w_cnt_i + PW'(r_in_map[i]);
            w_cnt_f      = w_cnt_f + PW'(r_flt_map[i]);
        end
    end

    // Lane selection and multiply-accumulate: lane l takes the (l+1)-th lowest
    // pending bit; lanes with nothing left contribute zero
    always_comb begin
        logic [CHUNK_SIZE-1:0]  w_rem;
        logic [PW-1:0]          w_pos;
        logic signed [Q-1:0]    w_a;
        logic signed [Q-1:0]    w_b;
        logic signed [2*Q-1:0]  w_prod;
        w_rem      = r_pending;
        w_pos      = '0;
        w_a        = '0;
        w_b        = '0;
        w_prod     = '0;
        w_used     = '0;
        w_acc_next = r_acc;
        for (int l = 0; l < LANES; l++) begin
            if (w_rem != '0) begin
                w_pos = '0;
                for (int i = CHUNK_SIZE - 1; i >= 0; i--) begin
                    if (w_rem[i]) w_pos = PW'(i);
                end
                w_a        = r_in_data[w_in_pre[w_pos]*Q +: Q];
                w_b        = r_flt_data[w_flt_pre[w_pos]*Q +: Q];
                w_prod     = w_a * w_b;
                w_acc_next = w_acc_next + {{(ACC_W-2*Q){w_prod[2*Q-1]}}, w_prod};
                w_used     = w_used + LW'(1);
                // drop the lowest set bit
                w_rem      = w_rem & (w_rem - ONE_C);
            end
        end
        w_pending_next = w_rem;
    end

    // Datapath: capture chunk at accept, advance accumulator and counter in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_map      <= '0;
            r_flt_map     <= '0;
            r_in_data     <= '0;
            r_flt_data    <= '0;
            r_pending     <= '0;
            r_acc         <= '0;
            r_match_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_map      <= bus.input_sparsemap;
                        r_flt_map     <= bus.filter_sparsemap;
                        r_in_data     <= bus.input_data;
                        r_flt_data    <= bus.filter_data;
                        r_pending     <= bus.input_sparsemap & bus.filter_sparsemap;
                        r_match_count <= '0;
                        if (bus.acc_clear) r_acc <= '0;
                    end
                end
                S_RUN: begin
                    r_acc         <= w_acc_next;
                    r_pending     <= w_pending_next;
                    r_match_count <= r_match_count + MC_W'(w_used);
                end
                default: ;
            endcase
        end
    end

`ifdef SPARTEN_RELU_EN
    // Presented result clamps negatives to zero; accumulator stays raw
    assign bus.result = r_acc[ACC_W-1] ? '0 : r_acc;
`else
    // Presented result is the raw accumulator
    assign bus.result = r_acc;
`endif

    assign bus.match_count = r_match_count;
    assign o_state         = r_state;

endmodule

// File: tb/tb_sparten_mac_engine.sv
// tb_sparten_mac_engine: directed tests with hand-computed expectations.
module tb_sparten_mac_engine;
    localparam int CS    = 128;
    localparam int Q     = 8;
    localparam int LANES = 2;
    localparam int ACC_W = 2*Q + $clog2(CS);
    localparam int MC_W  = $clog2(CS) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    int n_err = 0;
    int n_chk = 0;

    logic [ACC_W-1:0] exp_q[$];

    logic [CS-1:0]   t_imap;
    logic [CS-1:0]   t_fmap;
    logic [CS*Q-1:0] t_idata;
    logic [CS*Q-1:0] t_fdata;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sparten_mac_engine_if #(.CHUNK_SIZE(CS), .Q(Q)) bus ();

    sparten_mac_engine #(
        .CHUNK_SIZE(CS), .Q(Q), .LANES(LANES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] acc_of(input int v);
        return v[ACC_W-1:0];
    endfunction

    function automatic int shown(input int v);
`ifdef SPARTEN_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic prep();
        t_imap = '0;
        t_fmap = '0;
        for (int k = 0; k < CS; k++) begin
            t_idata[k*Q +: Q] = Q'($urandom_range(0, 255));
            t_fdata[k*Q +: Q] = Q'($urandom_range(0, 255));
        end
    endtask

    task automatic set_i(input int k, input int v);
        t_idata[k*Q +: Q] = v[Q-1:0];
    endtask

    task automatic set_f(input int k, input int v);
        t_fdata[k*Q +: Q] = v[Q-1:0];
    endtask

    task automatic accept_result(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_ovalid_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_iready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    // Offer the current chunk, count RUN cycles, check the result
    task automatic run_chunk(input string tag, input bit clr, input int exp_cyc,
                             input int exp_res, input int exp_mc, input bit accept);
        int cyc;
        logic [ACC_W-1:0] exp_r;
        exp_q.push_back(acc_of(shown(exp_res)));
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
        bus.input_sparsemap  = t_imap;
        bus.filter_sparsemap = t_fmap;
        bus.input_data       = t_idata;
        bus.filter_data      = t_fdata;
        bus.acc_clear        = clr;
        bus.in_valid         = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
        cyc = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.out_valid) break;
        end
        check({tag, "_ovalid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        exp_r = exp_q.pop_front();
        check({tag, "_result"}, 64'(bus.result), 64'(exp_r));
        check({tag, "_mcount"}, 64'(bus.match_count), 64'(exp_mc));
        if (accept) accept_result(tag);
    endtask

    // Three matches at 5, 20, 100 with extra unmatched bits; products 4, 5, 6
    task automatic load_three();
        prep();
        t_imap[1] = 1'b1; t_imap[5] = 1'b1; t_imap[20] = 1'b1;
        t_imap[60] = 1'b1; t_imap[100] = 1'b1;
        t_fmap[5] = 1'b1; t_fmap[20] = 1'b1; t_fmap[100] = 1'b1; t_fmap[127] = 1'b1;
        set_i(0, 11); set_i(1, 2); set_i(2, 5); set_i(3, -7); set_i(4, 3);
        set_f(0, 2);  set_f(1, 1); set_f(2, 2); set_f(3, 99);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.in_valid         = 1'b0;
        bus.out_ready        = 1'b0;
        bus.acc_clear        = 1'b0;
        bus.input_sparsemap  = '0;
        bus.filter_sparsemap = '0;
        bus.input_data       = '0;
        bus.filter_data      = '0;

        // reset state
        #12;
        check("rst_ovalid", 64'(bus.out_valid), 64'd0);
        check("rst_iready", 64'(bus.in_ready), 64'd1);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_mcount", 64'(bus.match_count), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // full maps: 128 matches of 1*2, two per cycle
        prep();
        t_imap = '1;
        t_fmap = '1;
        for (int k = 0; k < CS; k++) begin
            set_i(k, 1);
            set_f(k, 2);
        end
        run_chunk("full", 1'b1, 64, 256, 128, 1'b1);

        // single match at 10: input idx 1 (-3), filter idx 0 (5)
        prep();
        t_imap[3] = 1'b1; t_imap[10] = 1'b1;
        t_fmap[10] = 1'b1; t_fmap[50] = 1'b1;
        set_i(0, 7); set_i(1, -3);
        set_f(0, 5); set_f(1, 9);
        run_chunk("neg", 1'b1, 1, -15, 1, 1'b1);

        // 6*7 = 42 then a disjoint chunk carried on top
        prep();
        t_imap[0] = 1'b1;
        t_fmap[0] = 1'b1;
        set_i(0, 6);
        set_f(0, 7);
        run_chunk("p42", 1'b1, 1, 42, 1, 1'b1);
        prep();
        t_imap = {16{8'h0F}};
        t_fmap = {16{8'hF0}};
        run_chunk("disj", 1'b0, 1, 42, 0, 1'b1);

        // three matches, then the same chunk accumulated again
        load_three();
        run_chunk("three", 1'b1, 2, 15, 3, 1'b1);
        run_chunk("three_acc", 1'b0, 2, 30, 3, 1'b1);

        // five mixed-sign matches, last cycle uses one lane
        prep();
        t_imap[4:0] = 5'h1F;
        t_fmap[4:0] = 5'h1F;
        set_i(0, -128); set_i(1, 127); set_i(2, -1); set_i(3, 10); set_i(4, -5);
        set_f(0, -128); set_f(1, 127); set_f(2, 3);  set_f(3, -10); set_f(4, 0);
        run_chunk("mixed", 1'b1, 3, 32410, 5, 1'b1);

        // DONE hold with back-pressure and ignored in_valid pulses
        load_three();
        run_chunk("hold", 1'b1, 2, 15, 3, 1'b0);
        t_imap = '1;
        t_fmap = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_ovalid", 64'(bus.out_valid), 64'd1);
            check("hold_result", 64'(bus.result), 64'(acc_of(15)));
            check("hold_mcount", 64'(bus.match_count), 64'd3);
            check("hold_iready", 64'(bus.in_ready), 64'd0);
            bus.input_sparsemap  = t_imap;
            bus.filter_sparsemap = t_fmap;
            bus.acc_clear        = 1'b1;
            bus.in_valid         = (k % 2 == 0);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        accept_result("hold");
        check("hold_idle_state", 64'(dbg_state), 64'd0);
        check("hold_mcount_kept", 64'(bus.match_count), 64'd3);

        // reset in the 3rd RUN cycle of a 10-match chunk
        prep();
        t_imap[9:0] = 10'h3FF;
        t_fmap[9:0] = 10'h3FF;
        for (int k = 0; k < 10; k++) begin
            set_i(k, 1);
            set_f(k, 1);
        end
        @(negedge clk);
        bus.input_sparsemap  = t_imap;
        bus.filter_sparsemap = t_fmap;
        bus.input_data       = t_idata;
        bus.filter_data      = t_fdata;
        bus.acc_clear        = 1'b1;
        bus.in_valid         = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("abort_running", 64'(dbg_state), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ovalid", 64'(bus.out_valid), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_iready", 64'(bus.in_ready), 64'd1);
        check("abort_mcount", 64'(bus.match_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // accumulator restarts from 0 even without acc_clear
        load_three();
        run_chunk("after_rst", 1'b0, 2, 15, 3, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sparten_mac_engine.md
Name: sparten_mac_engine

Overview:
- Multi-lane successor to the single-match sparse compute unit in the SparTen-style sparse dot-product path.
- Accepts one chunk of bitmap-encoded sparse input and filter data through a valid/ready handshake.
- Inner-joins the two sparsemaps and retires up to LANES matched pairs per cycle, each through a prefix-sum lookup and a signed multiply.
- Accumulates into a wide accumulator that is either cleared or carried across chunks, then presents the result on a valid/ready output.

Parameters:
CHUNK_SIZE, 128, bitmap length and max nonzeros per operand per chunk
Q, 8, signed data width per value
LANES, 2, matched pairs retired per RUN cycle (1..8)
ACC_W, 2*Q+$clog2(CHUNK_SIZE), accumulator/result width, signed

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  chunk offered
in_ready  out  1  engine can accept chunk; equals (state==IDLE)
acc_clear  in  1  sampled with handshake; 1 = start accumulator from 0, 0 = continue from current accumulator
input_sparsemap  in  CHUNK_SIZE  input nonzero bitmap
filter_sparsemap  in  CHUNK_SIZE  filter nonzero bitmap
input_data  in  Q x CHUNK_SIZE  compacted input nonzeros; entry k = k-th set bit, LSB first
filter_data  in  Q x CHUNK_SIZE  compacted filter nonzeros, same packing
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  ACC_W  signed accumulated dot product
match_count  out  $clog2(CHUNK_SIZE)+1  number of matches in the last chunk

Behaviour:
- Reset values: state=IDLE, accumulator=0, result=0, match_count=0, out_valid=0, in_ready=1.
- Async reset mid-RUN or mid-DONE aborts the chunk with no partial output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On in_valid&&in_ready, register both maps and both data arrays.
  - pending <= input_sparsemap & filter_sparsemap.
  - If acc_clear, accumulator <= 0; clear and match_count reset occur at that same edge.
  - Go to RUN.
- RUN, each cycle:
  - Select up to LANES lowest set bits of pending.
  - For match position p: input index = popcount(input_map[p-1:0]); filter index = popcount(filter_map[p-1:0]).
  - Product = signed(Q) x signed(Q), 2Q bits, sign-extended to ACC_W.
  - All lane products plus the accumulator are summed in the same edge.
  - Selected bits are cleared from pending; match_count is incremented by the number of lanes used.
  - Go to DONE at the edge where pending becomes 0.
  - An empty join still spends exactly one RUN cycle, adding nothing.
- RUN length = max(1, ceil(M/LANES)) cycles, where M = popcount of the join.
  - out_valid rises at the edge ending the last RUN cycle.
  - Handshake at edge E0 gives out_valid visible after edge E_max(1,ceil(M/LANES)).
- DONE:
  - out_valid=1; result and match_count are held stable.
  - On out_ready, go to IDLE and drop out_valid at that edge; in_ready=1 the next cycle.
  - No new chunk is accepted in the same cycle as result acceptance.
- Arithmetic: two's complement; accumulator wraps modulo 2^ACC_W with no saturation. The accumulator persists across chunks until acc_clear.
- Unused lanes in the last RUN cycle contribute 0.
- Data entries beyond each map's popcount are ignored.
- in_valid while not in IDLE is ignored; the source must hold it.
- Ordering of lanes is fixed: lane i takes the (i+1)-th lowest set bit of pending.

Optional Feature:
- Macro: SPARTEN_RELU_EN.
- Defined: result = 0 when the accumulator is negative, else the accumulator. The internal accumulator keeps the raw signed value, so chained chunks remain exact.
- Undefined: result = raw accumulator.
- Identical latency and handshake in both builds.

Test Plan:
- Both maps all-ones, input_data all 1, filter_data all 2, acc_clear=1, LANES=2 -> 64 RUN cycles, out_valid after edge E64, result=256, match_count=128.
- Input map bits {3,10}, filter map bits {10,50}, input_data[1]=-3 (0xFD), filter_data[0]=5, acc_clear=1 -> 1 RUN cycle, match_count=1, result=-15; with SPARTEN_RELU_EN result=0.
- Disjoint maps (input 0x0F.., filter 0xF0..), acc_clear=0 after a prior result of 42 -> 1 RUN cycle, result=42, match_count=0.
- Three matches, LANES=2, products 4,5,6 -> 2 RUN cycles, result=15; second chunk with acc_clear=0 and the same data -> result=30.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, result and match_count stable, in_ready=0; in_valid pulses ignored; out_ready=1 -> IDLE next edge.
- Assert rst_n=0 in the 3rd RUN cycle of a 10-match chunk -> immediately out_valid=0, result=0, in_ready=1; the next chunk computes correctly from 0.
